// File: rtl/compare_pkg.sv
// Shared types and sizing helpers for the sequential slice comparator.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_CHUNK = 8;

  // Number of CHUNK-bit slices in a WIDTH-bit operand; guards against a zero chunk.
  function automatic int unsigned nslice(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_width(nslice(DEF_WIDTH, DEF_CHUNK));

endpackage

// File: rtl/compare_slice.sv
// Combinational CHUNK-bit slice compare with optional sign-bit flip for the top slice.
module compare_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             flip_msb,
  output logic             s_eq,
  output logic             s_lt
);

  logic [CHUNK-1:0] msb_mask;
  logic [CHUNK-1:0] a_f;
  logic [CHUNK-1:0] b_f;

  // Flipping the sign bit turns a two's-complement order into an unsigned one.
  always_comb begin
    msb_mask           = '0;
    msb_mask[CHUNK-1]  = flip_msb;
    a_f                = a_s ^ msb_mask;
    b_f                = b_s ^ msb_mask;
    s_eq               = &(a_s ~^ b_s);
    s_lt               = (a_f < b_f);
  end

endmodule

// File: rtl/compare_seq.sv
// Multi-cycle MSB-first magnitude/equality comparator with valid/ready on both sides.
module compare_seq
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned NSLICE = nslice(WIDTH, CHUNK);
  localparam int unsigned IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] TOP  = IW'(NSLICE - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("compare_seq: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_signed_q, op_signed_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CHUNK-1:0] sa_q, sa_d;
  logic [CHUNK-1:0] sb_q, sb_d;
  logic             flip_q, flip_d;
  logic             stage_v_q, stage_v_d;
  logic [IW-1:0]    stage_idx_q, stage_idx_d;
  logic             found_q, found_d;
  logic             res_lt_q, res_lt_d;
  logic             eq_d, lt_d, gt_d;
  logic             in_ready_d, out_valid_d;
  logic             diff;
  logic             s_eq, s_lt;

  logic [CHUNK-1:0] a_sl [NSLICE];
  logic [CHUNK-1:0] b_sl [NSLICE];

  for (genvar i = 0; i < NSLICE; i++) begin : g_sl
    assign a_sl[i] = op_a_q[i*CHUNK +: CHUNK];
    assign b_sl[i] = op_b_q[i*CHUNK +: CHUNK];
  end

  // The selected slice is registered before the compare, keeping mux and compare on separate cycles.
  compare_slice #(.CHUNK(CHUNK)) u_slice (
    .a_s      (sa_q),
    .b_s      (sb_q),
    .flip_msb (flip_q),
    .s_eq     (s_eq),
    .s_lt     (s_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_signed_q <= 1'b0;
      idx_q       <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      flip_q      <= 1'b0;
      stage_v_q   <= 1'b0;
      stage_idx_q <= '0;
      found_q     <= 1'b0;
      res_lt_q    <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      eq          <= 1'b0;
      lt          <= 1'b0;
      gt          <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_signed_q <= op_signed_d;
      idx_q       <= idx_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      flip_q      <= flip_d;
      stage_v_q   <= stage_v_d;
      stage_idx_q <= stage_idx_d;
      found_q     <= found_d;
      res_lt_q    <= res_lt_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      eq          <= eq_d;
      lt          <= lt_d;
      gt          <= gt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_signed_d = op_signed_q;
    idx_d       = idx_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    flip_d      = flip_q;
    stage_v_d   = stage_v_q;
    stage_idx_d = stage_idx_q;
    found_d     = found_q;
    res_lt_d    = res_lt_q;
    eq_d        = eq;
    lt_d        = lt;
    gt_d        = gt;
    diff        = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_a_d      = a;
          op_b_d      = b;
          op_signed_d = is_signed;
          idx_d       = TOP;
          stage_v_d   = 1'b0;
          found_d     = 1'b0;
          res_lt_d    = 1'b0;
          state_d     = RUN;
        end
      end

      RUN: begin
        // Fetch the next slice into the stage; idx parks at 0 once the scan is issued.
        sa_d        = a_sl[idx_q];
        sb_d        = b_sl[idx_q];
        flip_d      = op_signed_q && (idx_q == TOP);
        stage_idx_d = idx_q;
        stage_v_d   = 1'b1;
        if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end

        if (stage_v_q) begin
          diff = !s_eq;
          // Only the most significant difference decides the result.
          if (diff && !found_q) begin
            found_d  = 1'b1;
            res_lt_d = s_lt;
          end
          if ((EARLY_EXIT && diff) || (stage_idx_q == '0)) begin
            state_d = DONE;
            eq_d    = !found_d;
            lt_d    = found_d && res_lt_d;
            gt_d    = found_d && !res_lt_d;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq: early-exit and fixed-latency instances checked against a behavioural model.
module tb_compare_seq;

  localparam int NS = 8;
  localparam int CH = 8;
  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a, b;
  logic        is_signed;

  logic rdy_e, vld_e, eq_e, lt_e, gt_e;
  logic rdy_f, vld_f, eq_f, lt_f, gt_f;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic       active;
  logic [2:0] exp_fl;
  int         exp_le, exp_lf;
  int         t_acc;
  logic       seen_e, seen_f;
  int         lat_e, lat_f;
  logic [2:0] cap_e, cap_f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  compare_seq #(.WIDTH(64), .CHUNK(8), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_e),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(vld_e), .out_ready(out_ready),
    .eq(eq_e), .lt(lt_e), .gt(gt_e)
  );

  compare_seq #(.WIDTH(64), .CHUNK(8), .EARLY_EXIT(1'b0)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(vld_f), .out_ready(out_ready),
    .eq(eq_f), .lt(lt_f), .gt(gt_f)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result from plain integer comparison; latency from the position of the first differing byte.
  task automatic set_model(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic lt_m;
    lt_m   = s ? ($signed(x) < $signed(y)) : (x < y);
    exp_fl = (x == y) ? F_EQ : (lt_m ? F_LT : F_GT);
    exp_lf = 1 + NS;
    exp_le = 1 + NS;
    for (int k = NS - 1; k >= 0; k--) begin
      if (x[k*CH +: CH] != y[k*CH +: CH]) begin
        exp_le = 1 + (NS - k);
        break;
      end
    end
  endtask

  // One clock step; outputs are sampled on the falling edge and checked against the model.
  task automatic tick();
    @(negedge clk);
    if (active && rst_n) begin
      if (vld_e) begin
        chk("flags_e", {eq_e, lt_e, gt_e}, exp_fl);
        chk("busy_rdy_e", rdy_e, 1'b0);
        if (!seen_e) begin
          seen_e = 1'b1;
          lat_e  = cyc - t_acc;
          cap_e  = {eq_e, lt_e, gt_e};
          chk("lat_e", lat_e, exp_le);
        end
      end
      if (vld_f) begin
        chk("flags_f", {eq_f, lt_f, gt_f}, exp_fl);
        chk("busy_rdy_f", rdy_f, 1'b0);
        if (!seen_f) begin
          seen_f = 1'b1;
          lat_f  = cyc - t_acc;
          cap_f  = {eq_f, lt_f, gt_f};
          chk("lat_f", lat_f, exp_lf);
        end
      end
    end
  endtask

  task automatic start(input logic [63:0] x, input logic [63:0] y, input logic s);
    a         = x;
    b         = y;
    is_signed = s;
    in_valid  = 1'b1;
    set_model(x, y, s);
    t_acc     = cyc + 1;
    seen_e    = 1'b0;
    seen_f    = 1'b0;
    active    = 1'b1;
  endtask

  task automatic wait_result();
    for (int n = 0; n < 40 && !(seen_e && seen_f); n++) tick();
    chk("done_e", seen_e, 1'b1);
    chk("done_f", seen_f, 1'b1);
  endtask

  task automatic run(input logic [63:0] x, input logic [63:0] y, input logic s,
                     input logic hand, input logic [2:0] hfl, input int hle, input int hlf);
    tick();
    chk("idle_rdy_e", rdy_e, 1'b1);
    chk("idle_rdy_f", rdy_f, 1'b1);
    out_ready = 1'b1;
    start(x, y, s);
    tick();
    in_valid  = 1'b0;
    a         = {$urandom, $urandom};
    b         = {$urandom, $urandom};
    is_signed = ~s;
    chk("accepted_e", rdy_e, 1'b0);
    wait_result();
    if (hand) begin
      chk("hand_lat_e", lat_e, hle);
      chk("hand_lat_f", lat_f, hlf);
      chk("hand_flags_e", cap_e, hfl);
      chk("hand_flags_f", cap_f, hfl);
    end
    tick();
    active = 1'b0;
  endtask

  initial begin
    logic [63:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; is_signed = 1'b0; active = 1'b0;
    seen_e = 1'b0; seen_f = 1'b0; lat_e = 0; lat_f = 0;
    cap_e = '0; cap_f = '0; t_acc = 0; exp_fl = '0; exp_le = 0; exp_lf = 0;
    tick(); tick();
    chk("rst_rdy_e", rdy_e, 1'b1);
    chk("rst_vld_e", vld_e, 1'b0);
    chk("rst_flags_e", {eq_e, lt_e, gt_e}, 3'b000);
    chk("rst_rdy_f", rdy_f, 1'b1);
    chk("rst_flags_f", {vld_f, eq_f, lt_f, gt_f}, 4'b0000);
    rst_n = 1'b1;

    run(64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, F_EQ, 9, 9);
    run(64'h0100_0000_0000_0000, 64'h0200_0000_0000_0000, 1'b0, 1'b1, F_LT, 2, 9);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b1, F_LT, 2, 9);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, F_GT, 2, 9);
    run(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, F_LT, 2, 9);
    run(64'h0000_0012_0000_0000, 64'h0000_0011_FFFF_FFFF, 1'b0, 1'b1, F_GT, 5, 9);
    run(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, F_LT, 9, 9);

    // Abort mid-scan with an asynchronous reset.
    tick();
    start(64'h1234, 64'h1235, 1'b0);
    active = 1'b0;
    tick(); in_valid = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rdy_e", rdy_e, 1'b1);
    chk("abort_out_e", {vld_e, eq_e, lt_e, gt_e}, 4'b0000);
    chk("abort_rdy_f", rdy_f, 1'b1);
    chk("abort_out_f", {vld_f, eq_f, lt_f, gt_f}, 4'b0000);
    @(posedge clk); #1;
    chk("abort_hold_e", {rdy_e, vld_e, eq_e, lt_e, gt_e}, 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    run(64'h0000_0000_0000_0300, 64'h0000_0000_0000_0200, 1'b0, 1'b1, F_GT, 8, 9);

    // Back-pressure with in_valid held high the whole time.
    tick();
    chk("bp_idle_e", rdy_e, 1'b1);
    out_ready = 1'b0;
    start(64'h5, 64'h4, 1'b0);
    tick();
    a = 64'h7;
    b = 64'h9;
    wait_result();
    chk("bp_lat_e", lat_e, 9);
    chk("bp_lat_f", lat_f, 9);
    chk("bp_flags_e", cap_e, F_GT);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vld_e", vld_e, 1'b1);
      chk("stall_rdy_e", rdy_e, 1'b0);
      chk("stall_vld_f", vld_f, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk("handoff_vld_e", vld_e, 1'b0);
    chk("handoff_rdy_e", rdy_e, 1'b1);
    chk("handoff_vld_f", vld_f, 1'b0);
    set_model(64'h7, 64'h9, 1'b0);
    t_acc  = cyc + 1;
    seen_e = 1'b0;
    seen_f = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("bp_accept_e", rdy_e, 1'b0);
    wait_result();
    chk("bp2_lat_e", lat_e, 9);
    chk("bp2_flags_e", cap_e, F_LT);
    tick();
    active = 1'b0;

    // A few random pairs differing in one random byte, checked by the model only.
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = ra ^ (64'($urandom_range(255, 1)) << (8 * $urandom_range(7, 0)));
      run(ra, rb, 1'($urandom_range(1, 0)), 1'b0, F_EQ, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
